// File: rtl/fir_filter_mac.sv
// fir_filter_mac: programmable-coefficient FIR filter that time-shares one
// multiply-accumulate unit across all taps, one sample per TAPS+2 cycles.
module fir_filter_mac #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8,
    parameter int OUT_W  = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       x_in,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]       coef_wdata,
    output logic                    out_valid,
    output logic [OUT_W-1:0]        y_out
);
    localparam int AW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + AW;
    localparam logic [AW:0]   TAPS_LIM = (AW + 1)'(TAPS);
    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;
    state_e state;

    logic signed [DATA_W-1:0] tap  [TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic [AW-1:0]            idx;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic [OUT_W-1:0]         y_sat;
    logic                     coef_ok;

    assign in_ready = (state == StIdle);

    // Single shared multiplier, operands selected by the running tap index.
    assign prod     = PROD_W'(tap[idx]) * PROD_W'(coef[idx]);
    assign prod_ext = ACC_W'(prod);

    // Writes only land in IDLE so a sample never sees a half-updated coefficient set;
    // out-of-range addresses (non-power-of-2 TAPS) are dropped.
    assign coef_ok = coef_we && (state == StIdle) && ({1'b0, coef_addr} < TAPS_LIM);

    generate
        if (OUT_W >= ACC_W) begin : g_sext
            assign y_sat = OUT_W'(acc);
        end else begin : g_sat
            logic [ACC_W-OUT_W:0] top;
            assign top = acc[ACC_W-1:OUT_W-1];
            // Clamp when the bits above the output sign bit are not a pure sign extension.
            always_comb begin
                if (top == '0 || top == '1) begin
                    y_sat = acc[OUT_W-1:0];
                end else if (acc[ACC_W-1]) begin
                    y_sat = {1'b1, {(OUT_W - 1){1'b0}}};
                end else begin
                    y_sat = {1'b0, {(OUT_W - 1){1'b1}}};
                end
            end
        end
    endgenerate

    // Control FSM with delay line, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            acc       <= '0;
            idx       <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                tap[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        tap[0] <= x_in;
                        for (int i = 1; i < TAPS; i++) begin
                            tap[i] <= tap[i-1];
                        end
                        acc   <= '0;
                        idx   <= '0;
                        state <= StMac;
                    end
                end
                StMac: begin
                    acc <= acc + prod_ext;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= StOut;
                    end
                end
                StOut: begin
                    y_out     <= y_sat;
                    out_valid <= 1'b1;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Coefficient register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (coef_ok) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

endmodule
